// File: rtl/btn_pkg.sv
// Button conditioner shared types and default timing.
// Timing defaults assume a 25 MHz clock.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rpt_state_t;

  localparam int DEF_NUM_BTN       = 7;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_DEBOUNCE      = 250000;
  localparam int DEF_REPEAT_DELAY  = 12500000;
  localparam int DEF_REPEAT_PERIOD = 2500000;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchronizer, debouncer,
// edge pulses and auto-repeat FSM.
module btn_channel
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int DEBOUNCE      = DEF_DEBOUNCE,
  parameter int ACTIVE_LOW    = 0,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int CW            = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_async,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt
);

  localparam logic IDLE_RAW = (ACTIVE_LOW != 0);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CW-1:0]          db_cnt;
  logic                   db_hit;
  logic                   rise;
  logic                   fall;

  rpt_state_t    state_q;
  rpt_state_t    state_d;
  logic [CW-1:0] rcnt_q;
  logic [CW-1:0] rcnt_d;
  logic          rpt_d;

  // Shift raw pin into the synchronizer; reset to the idle pin level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{IDLE_RAW}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_async};
    end
  end

  assign s      = sync_q[SYNC_STAGES-1] ^ IDLE_RAW;
  assign db_hit = (s != level) &&
                  (db_cnt == CW'(DEBOUNCE - 1));
  assign rise   = db_hit && !level;
  assign fall   = db_hit && level;

  // Count consecutive disagreeing samples; toggle level when enough
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level  <= 1'b0;
      db_cnt <= '0;
      press  <= 1'b0;
      rel    <= 1'b0;
    end else begin
      press <= rise;
      rel   <= fall;
      if (s == level || db_hit) begin
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CW'(1);
      end
      if (db_hit) begin
        level <= ~level;
      end
    end
  end

  // Repeat FSM state, counter and registered repeat pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
      rpt     <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      rpt     <= rpt_d;
    end
  end

  // Next-state logic; a release always wins over a due repeat
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rpt_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = DELAY;
          rcnt_d  = '0;
        end
      end
      DELAY: begin
        if (fall) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == CW'(REPEAT_DELAY - 1)) begin
          state_d = REPEAT;
          rcnt_d  = '0;
          rpt_d   = 1'b1;
        end else begin
          rcnt_d = rcnt_q + CW'(1);
        end
      end
      REPEAT: begin
        if (fall) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == CW'(REPEAT_PERIOD - 1)) begin
          rcnt_d = '0;
          rpt_d  = 1'b1;
        end else begin
          rcnt_d = rcnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        rcnt_d  = '0;
      end
    endcase
    if (REPEAT_EN == 0) begin
      state_d = IDLE;
      rcnt_d  = '0;
      rpt_d   = 1'b0;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel button conditioner top level.
// release is a reserved word, so the release pulse is named rel.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int NUM_BTN         = DEF_NUM_BTN,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int ACTIVE_LOW      = 0,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_async,
  output logic [NUM_BTN-1:0] level,
  output logic [NUM_BTN-1:0] press,
  output logic [NUM_BTN-1:0] rel,
  output logic [NUM_BTN-1:0] rpt
);

  localparam int CW = $clog2(max3(DEBOUNCE_CYCLES,
                                  REPEAT_DELAY,
                                  REPEAT_PERIOD) + 1);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEBOUNCE     (DEBOUNCE_CYCLES),
      .ACTIVE_LOW   (ACTIVE_LOW),
      .REPEAT_EN    (REPEAT_EN),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .CW           (CW)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .btn_async(btn_async[i]),
      .level    (level[i]),
      .press    (press[i]),
      .rel      (rel[i]),
      .rpt      (rpt[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner against a
// window-based reference model of debounce and repeat timing.
module tb_btn_conditioner;

  localparam int NB = 7;
  localparam int SS = 2;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn = '0;
  logic [NB-1:0] btn_al = '1;
  logic [NB-1:0] level, press, rel, rpt;
  logic [NB-1:0] level2, press2, rel2, rpt2;

  int n_tests = 0;
  int n_fail  = 0;

  bit            hq [NB][$];
  bit            m_lvl [NB];
  int            pt [NB];
  int            t = 0;
  logic [NB-1:0] e_lvl, e_pr, e_rl, e_rp;

  always #5 clk = ~clk;

  btn_conditioner #(
    .NUM_BTN(NB), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
    .ACTIVE_LOW(0), .REPEAT_EN(1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .btn_async(btn),
    .level(level), .press(press), .rel(rel), .rpt(rpt)
  );

  btn_conditioner #(
    .NUM_BTN(NB), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
    .ACTIVE_LOW(1), .REPEAT_EN(1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_al (
    .clk(clk), .rst(rst), .btn_async(btn_al),
    .level(level2), .press(press2), .rel(rel2), .rpt(rpt2)
  );

  task automatic model_reset();
    for (int c = 0; c < NB; c++) begin
      hq[c].delete();
      for (int k = 0; k < SS + DB; k++) hq[c].push_back(1'b0);
      m_lvl[c] = 1'b0;
      pt[c] = 0;
    end
    e_lvl = '0; e_pr = '0; e_rl = '0; e_rp = '0;
  endtask

  // Level flips once the last DB synchronized samples all disagree with it;
  // repeats fall at press+RD+n*RP while the level stays high.
  task automatic step();
    logic [NB-1:0] r;
    logic rs;
    bit diff;
    bit nl;
    r  = btn;
    rs = rst;
    @(posedge clk);
    t++;
    if (rs) begin
      model_reset();
    end else begin
      for (int c = 0; c < NB; c++) begin
        diff = 1'b1;
        for (int k = 0; k < DB; k++)
          if (hq[c][hq[c].size() - SS - k] == m_lvl[c]) diff = 1'b0;
        nl = diff ? ~m_lvl[c] : m_lvl[c];
        e_pr[c] = nl & ~m_lvl[c];
        e_rl[c] = ~nl & m_lvl[c];
        if (e_pr[c]) pt[c] = t;
        e_rp[c] = nl && !e_pr[c] && (t - pt[c] >= RD) &&
                  ((t - pt[c] - RD) % RP == 0);
        m_lvl[c] = nl;
        e_lvl[c] = nl;
        hq[c].push_back(r[c]);
        if (hq[c].size() > SS + DB) void'(hq[c].pop_front());
      end
    end
    #1;
  endtask

  task automatic settle();
    btn = '0;
    repeat (SS + DB + RP + 6) step();
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if ({level, press, rel, rpt, level2, press2, rel2, rpt2} !== '0) begin
      n_fail++;
      $display("FAIL reset_async got %b %b %b %b / %b %b %b %b want all 0",
               level, press, rel, rpt, level2, press2, rel2, rpt2);
    end
    repeat (2) step();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      n_tests++;
      if ({level, press, rel, rpt, level2, press2, rel2, rpt2} !== '0) begin
        n_fail++;
        $display("FAIL reset_idle k=%0d got %b %b %b %b / %b %b %b %b want 0",
                 k, level, press, rel, rpt, level2, press2, rel2, rpt2);
      end
    end
  endtask

  task automatic test_clean_press();
    btn[1] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_tests++;
      if ({level, press, rel, rpt} !== {e_lvl, e_pr, e_rl, e_rp}) begin
        n_fail++;
        $display("FAIL clean_press k=%0d got %b %b %b %b want %b %b %b %b",
                 k, level, press, rel, rpt, e_lvl, e_pr, e_rl, e_rp);
      end
      if (k == 6) begin
        n_tests++;
        if ({level[1], press[1]} !== 2'b11) begin
          n_fail++;
          $display("FAIL clean_press_c6 got lvl=%b pr=%b want 1 1",
                   level[1], press[1]);
        end
      end
      if (k == 7) begin
        n_tests++;
        if (press[1] !== 1'b0) begin
          n_fail++;
          $display("FAIL clean_press_c7 got pr=%b want 0", press[1]);
        end
      end
    end
    settle();
  endtask

  task automatic test_bounce();
    btn[2] = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      if (k == 4) btn[2] = 1'b0;
      step();
      n_tests++;
      if ({level[2], press[2], rel[2]} !== 3'b000 ||
          {level, press, rel, rpt} !== {e_lvl, e_pr, e_rl, e_rp}) begin
        n_fail++;
        $display("FAIL bounce k=%0d got lvl=%b pr=%b rl=%b want 0 0 0",
                 k, level[2], press[2], rel[2]);
      end
    end
    settle();
  endtask

  task automatic test_hold();
    bit seen;
    seen = 1'b0;
    btn[1] = 1'b1;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      seen = (press[1] === 1'b1);
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL hold_press got no press within 20 cycles want press");
      settle();
      return;
    end
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 17) btn[1] = 1'b0;
      n_tests++;
      if ({level, press, rel, rpt} !== {e_lvl, e_pr, e_rl, e_rp}) begin
        n_fail++;
        $display("FAIL hold k=%0d got %b %b %b %b want %b %b %b %b",
                 k, level, press, rel, rpt, e_lvl, e_pr, e_rl, e_rp);
      end
      if (k == 10 || k == 13 || k == 16) begin
        n_tests++;
        if (rpt[1] !== 1'b1) begin
          n_fail++;
          $display("FAIL hold_rpt P+%0d got rpt=%b want 1", k, rpt[1]);
        end
      end
      if (k == 23) begin
        n_tests++;
        if ({rel[1], level[1], rpt[1]} !== 3'b100) begin
          n_fail++;
          $display("FAIL hold_release got rl=%b lvl=%b rpt=%b want 1 0 0",
                   rel[1], level[1], rpt[1]);
        end
      end
      if (k > 23) begin
        n_tests++;
        if (rpt[1] !== 1'b0) begin
          n_fail++;
          $display("FAIL hold_no_rpt P+%0d got rpt=%b want 0", k, rpt[1]);
        end
      end
    end
    settle();
  endtask

  task automatic test_early_release();
    bit seen;
    int nrpt;
    seen = 1'b0;
    nrpt = 0;
    btn[3] = 1'b1;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      seen = (press[3] === 1'b1);
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL early_press got no press within 20 cycles want press");
      settle();
      return;
    end
    for (int k = 1; k <= 24; k++) begin
      step();
      if (k == 4) btn[3] = 1'b0;
      if (rpt[3] === 1'b1) nrpt++;
      n_tests++;
      if ({level, press, rel, rpt} !== {e_lvl, e_pr, e_rl, e_rp}) begin
        n_fail++;
        $display("FAIL early k=%0d got %b %b %b %b want %b %b %b %b",
                 k, level, press, rel, rpt, e_lvl, e_pr, e_rl, e_rp);
      end
      if (k == 10) begin
        n_tests++;
        if ({rel[3], rpt[3]} !== 2'b10) begin
          n_fail++;
          $display("FAIL early_release got rl=%b rpt=%b want 1 0",
                   rel[3], rpt[3]);
        end
      end
    end
    n_tests++;
    if (nrpt != 0) begin
      n_fail++;
      $display("FAIL early_rpt_count got %0d want 0", nrpt);
    end
    settle();
  endtask

  task automatic test_simultaneous();
    for (int ph = 0; ph < 2; ph++) begin
      btn = (ph == 0) ? '1 : '0;
      for (int k = 1; k <= 8; k++) begin
        step();
        n_tests++;
        if ({level, press, rel, rpt} !== {e_lvl, e_pr, e_rl, e_rp}) begin
          n_fail++;
          $display("FAIL simul ph=%0d k=%0d got %b %b %b %b want %b %b %b %b",
                   ph, k, level, press, rel, rpt, e_lvl, e_pr, e_rl, e_rp);
        end
        if (k == 6) begin
          n_tests++;
          if ((ph == 0 ? press : rel) !== 7'h7f) begin
            n_fail++;
            $display("FAIL simul_edge ph=%0d got %b want 1111111",
                     ph, (ph == 0 ? press : rel));
          end
        end
      end
    end
    settle();
  endtask

  task automatic test_reset_mid();
    btn[1] = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    #1;
    n_tests++;
    if ({level, press, rel, rpt} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async got %b %b %b %b want 0",
               level, press, rel, rpt);
    end
    repeat (2) step();
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_tests++;
      if ({level, press, rel, rpt} !== {e_lvl, e_pr, e_rl, e_rp}) begin
        n_fail++;
        $display("FAIL reset_mid k=%0d got %b %b %b %b want %b %b %b %b",
                 k, level, press, rel, rpt, e_lvl, e_pr, e_rl, e_rp);
      end
      if (k == 5 || k == 6) begin
        n_tests++;
        if (press[1] !== (k == 6)) begin
          n_fail++;
          $display("FAIL reset_mid_press k=%0d got %b want %b",
                   k, press[1], (k == 6));
        end
      end
    end
    settle();
  endtask

  task automatic test_active_low();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      n_tests++;
      if ({level2, press2, rel2, rpt2} !== '0) begin
        n_fail++;
        $display("FAIL al_idle k=%0d got %b %b %b %b want 0",
                 k, level2, press2, rel2, rpt2);
      end
    end
    btn_al = '0;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_tests++;
      if (press2 !== ((k == 6) ? 7'h7f : 7'h00) ||
          level2 !== ((k >= 6) ? 7'h7f : 7'h00)) begin
        n_fail++;
        $display("FAIL al_press k=%0d got pr=%b lvl=%b", k, press2, level2);
      end
    end
    btn_al = '1;
    settle();
  endtask

  task automatic test_random();
    int hold [NB];
    for (int c = 0; c < NB; c++) hold[c] = $urandom_range(24, 1);
    for (int k = 0; k < 800; k++) begin
      for (int c = 0; c < NB; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          btn[c] = ~btn[c];
          hold[c] = ($urandom_range(3, 0) == 0) ? $urandom_range(3, 1)
                                                : $urandom_range(28, 4);
        end
      end
      step();
      n_tests++;
      if ({level, press, rel, rpt} !== {e_lvl, e_pr, e_rl, e_rp}) begin
        n_fail++;
        $display("FAIL random k=%0d got %b %b %b %b want %b %b %b %b",
                 k, level, press, rel, rpt, e_lvl, e_pr, e_rl, e_rp);
      end
    end
    settle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_hold();
    test_early_release();
    test_simultaneous();
    test_reset_mid();
    test_active_low();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
